// File: rtl/mem_arb_pkg.sv
// Shared constants, types and helpers for the main-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ    = 3;
    localparam int unsigned REQ_CPU    = 0;
    localparam int unsigned REQ_SERIAL = 1;
    localparam int unsigned REQ_PAD    = 2;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned PORT_AW    = 16;

    typedef logic [PTR_W-1:0] req_id_t;

    // Tag for the single read that can be in flight through the memory.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    oor;
    } rd_tag_t;

    function automatic req_id_t next_id(input req_id_t id);
        return (id == req_id_t'(NUM_REQ - 1)) ? req_id_t'(0) : id + req_id_t'(1);
    endfunction

    function automatic logic [PORT_AW-1:0] addr_slice(input logic [NUM_REQ*PORT_AW-1:0] bus,
                                                      input req_id_t id);
        return bus[id*PORT_AW +: PORT_AW];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 3-way rotating priority encoder with lock and optional CPU priority.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    input  req_id_t            lock_owner,
    input  logic               lock_valid,
    output logic [NUM_REQ-1:0] win
);

    req_id_t idx;
    logic    found;

    always_comb begin
        win   = '0;
        idx   = ptr;
        found = 1'b0;
        if (lock_valid) begin
            win[lock_owner] = 1'b1;
        end else if ((CPU_PRIORITY != 0) && req[REQ_CPU]) begin
            win[REQ_CPU] = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[idx]) begin
                    win[idx] = 1'b1;
                    found    = 1'b1;
                end
                idx = next_id(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the CPU-side main-memory port among CPU, loader and gamepad.
// ADDR_W must be below 16; upper requester address bits flag out-of-range accesses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*PORT_AW-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        cpu_stall,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    logic [NUM_REQ-1:0] win;
    req_id_t            win_id;
    logic               any_win;
    logic [PORT_AW-1:0] win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_oor;
    logic               lock_valid;

    req_id_t            ptr_q;
    req_id_t            lock_owner_q;
    logic               lock_act_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    rd_tag_t            rd_tag_q;
    logic [NUM_REQ-1:0] rvalid_q;
    logic               rv_oor_q;
    logic [DATA_W-1:0]  rdata_hold_q;

    // The previous winner keeps the port only while it still asserts both req and lock.
    assign lock_valid = lock_act_q & req[lock_owner_q] & lock[lock_owner_q];

    rr_pick #(.CPU_PRIORITY(CPU_PRIORITY)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .lock_owner (lock_owner_q),
        .lock_valid (lock_valid),
        .win        (win)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_id = req_id_t'(i);
        end
    end

    assign any_win   = |win;
    assign win_addr  = addr_slice(addr, win_id);
    assign win_wdata = wdata[win_id*DATA_W +: DATA_W];
    assign win_oor   = |win_addr[PORT_AW-1:ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            lock_owner_q <= '0;
            lock_act_q   <= 1'b0;
            gnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_tag_q     <= '0;
            rvalid_q     <= '0;
            rv_oor_q     <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            gnt_q          <= win;
            rd_tag_q.valid <= any_win & ~we[win_id];
            rd_tag_q.id    <= win_id;
            rd_tag_q.oor   <= win_oor;
            rvalid_q       <= '0;
            if (rd_tag_q.valid) rvalid_q[rd_tag_q.id] <= 1'b1;
            rv_oor_q       <= rd_tag_q.oor;
            if (any_win) begin
                ptr_q        <= next_id(win_id);
                lock_owner_q <= win_id;
                lock_act_q   <= lock[win_id];
                mem_we_q     <= we[win_id] & ~win_oor;
                mem_addr_q   <= win_addr[ADDR_W-1:0];
                mem_wdata_q  <= win_wdata;
            end else begin
                lock_act_q   <= 1'b0;
                mem_we_q     <= 1'b0;
            end
            if (|rvalid_q) rdata_hold_q <= rv_oor_q ? DATA_W'(0) : mem_rdata;
        end
    end

    // Memory output arrives in the rvalid cycle, so rdata passes it through then and holds after.
    assign rdata     = (|rvalid_q) ? (rv_oor_q ? DATA_W'(0) : mem_rdata) : rdata_hold_q;
    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign cpu_stall = req[REQ_CPU] & ~gnt_q[REQ_CPU];
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus reset and CPU-priority sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0, lock = '0, we = '0;
    logic [47:0] addr = '0, wdata = '0;
    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, mem_we;
    logic [13:0] mem_addr;

    logic [2:0]  preq = '0, plock = '0, pwe = '0;
    logic [47:0] paddr = '0, pwdata = '0;
    logic [2:0]  pgnt, prvalid;
    logic [15:0] prdata, pmem_wdata;
    logic [15:0] pmem_rdata = '0;
    logic        pcpu_stall, pmem_we;
    logic [13:0] pmem_addr;

    logic [15:0] mem [0:16383];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(16), .CPU_PRIORITY(0)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .cpu_stall(cpu_stall), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(16), .CPU_PRIORITY(1)) dut_p (
        .clk(clk), .rst(rst), .req(preq), .lock(plock), .we(pwe), .addr(paddr), .wdata(pwdata),
        .gnt(pgnt), .rvalid(prvalid), .rdata(prdata), .cpu_stall(pcpu_stall), .mem_we(pmem_we),
        .mem_addr(pmem_addr), .mem_wdata(pmem_wdata), .mem_rdata(pmem_rdata)
    );

    // Read-first synchronous block RAM with one cycle of read latency.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    typedef struct {
        logic [2:0]  req, lock, we;
        logic [15:0] a0, a1, a2, d0, d1, d2;
        logic        stall;
        logic [2:0]  gnt, rv;
        logic        mwe;
        logic        chk_rd;
        logic [15:0] rd;
        logic        chk_ma;
        logic [13:0] ma;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mkv(logic [2:0] r, logic [2:0] l, logic [2:0] w,
                                 logic [15:0] a0, logic [15:0] a1, logic [15:0] a2,
                                 logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
                                 logic st, logic [2:0] g, logic [2:0] rv, logic mwe,
                                 logic crd, logic [15:0] rd, logic cma, logic [13:0] ma);
        vec_t v;
        v.req = r; v.lock = l; v.we = w;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.stall = st; v.gnt = g; v.rv = rv; v.mwe = mwe;
        v.chk_rd = crd; v.rd = rd; v.chk_ma = cma; v.ma = ma;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
        mem[14'h0000] = 16'h5A5A;
        mem[14'h0010] = 16'hBEEF;
        mem[14'h0020] = 16'h1111;
        mem[14'h0021] = 16'h2222;
        mem[14'h0022] = 16'h3333;

        // single CPU read
        vecs[0]  = mkv(3'b001, 3'b000, 3'b000, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b000, 0, 0, 16'h0, 1, 14'h0010);
        vecs[1]  = mkv(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b001, 0, 1, 16'hBEEF, 1, 14'h0010);
        vecs[2]  = mkv(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b000, 0, 1, 16'hBEEF, 0, 14'h0);
        // all three reading, pointer sits at 1 after the CPU grant
        vecs[3]  = mkv(3'b111, 3'b000, 3'b000, 16'h0020, 16'h0021, 16'h0022, 16'h0, 16'h0, 16'h0, 1, 3'b010, 3'b000, 0, 0, 16'h0, 1, 14'h0021);
        vecs[4]  = mkv(3'b111, 3'b000, 3'b000, 16'h0020, 16'h0021, 16'h0022, 16'h0, 16'h0, 16'h0, 1, 3'b100, 3'b010, 0, 1, 16'h2222, 1, 14'h0022);
        vecs[5]  = mkv(3'b111, 3'b000, 3'b000, 16'h0020, 16'h0021, 16'h0022, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b100, 0, 1, 16'h3333, 1, 14'h0020);
        vecs[6]  = mkv(3'b111, 3'b000, 3'b000, 16'h0020, 16'h0021, 16'h0022, 16'h0, 16'h0, 16'h0, 0, 3'b010, 3'b001, 0, 1, 16'h1111, 1, 14'h0021);
        vecs[7]  = mkv(3'b111, 3'b000, 3'b000, 16'h0020, 16'h0021, 16'h0022, 16'h0, 16'h0, 16'h0, 1, 3'b100, 3'b010, 0, 1, 16'h2222, 0, 14'h0);
        vecs[8]  = mkv(3'b111, 3'b000, 3'b000, 16'h0020, 16'h0021, 16'h0022, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b100, 0, 1, 16'h3333, 0, 14'h0);
        vecs[9]  = mkv(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b001, 0, 1, 16'h1111, 1, 14'h0020);
        // locked write burst from requester 1 while the CPU waits to read it back
        vecs[10] = mkv(3'b011, 3'b010, 3'b010, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'hA000, 16'h0, 1, 3'b010, 3'b000, 1, 0, 16'h0, 1, 14'h0100);
        vecs[11] = mkv(3'b011, 3'b010, 3'b010, 16'h0100, 16'h0101, 16'h0, 16'h0, 16'hA001, 16'h0, 1, 3'b010, 3'b000, 1, 0, 16'h0, 1, 14'h0101);
        vecs[12] = mkv(3'b011, 3'b010, 3'b010, 16'h0100, 16'h0102, 16'h0, 16'h0, 16'hA002, 16'h0, 1, 3'b010, 3'b000, 1, 0, 16'h0, 1, 14'h0102);
        vecs[13] = mkv(3'b011, 3'b010, 3'b010, 16'h0100, 16'h0103, 16'h0, 16'h0, 16'hA003, 16'h0, 1, 3'b010, 3'b000, 1, 0, 16'h0, 1, 14'h0103);
        vecs[14] = mkv(3'b001, 3'b000, 3'b000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b000, 0, 0, 16'h0, 1, 14'h0100);
        vecs[15] = mkv(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b001, 0, 1, 16'hA000, 0, 14'h0);
        vecs[16] = mkv(3'b100, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0103, 16'h0, 16'h0, 16'h0, 0, 3'b100, 3'b000, 0, 0, 16'h0, 1, 14'h0103);
        vecs[17] = mkv(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b100, 0, 1, 16'hA003, 0, 14'h0);
        // out-of-range write then read from the gamepad writer
        vecs[18] = mkv(3'b100, 3'b000, 3'b100, 16'h0, 16'h0, 16'hC000, 16'h0, 16'h0, 16'h1234, 0, 3'b100, 3'b000, 0, 0, 16'h0, 1, 14'h0000);
        vecs[19] = mkv(3'b100, 3'b000, 3'b000, 16'h0, 16'h0, 16'hC000, 16'h0, 16'h0, 16'h0, 0, 3'b100, 3'b000, 0, 0, 16'h0, 1, 14'h0000);
        vecs[20] = mkv(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b100, 0, 1, 16'h0000, 0, 14'h0);
        vecs[21] = mkv(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b000, 0, 1, 16'h0000, 0, 14'h0);

        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_pgnt", 32'(pgnt), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            req   = vecs[i].req;
            lock  = vecs[i].lock;
            we    = vecs[i].we;
            addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
            wdata = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
            #1;
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
            tick();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].rd));
            if (vecs[i].chk_ma) chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].ma));
        end
        chk("oor_write_blocked", 32'(mem[14'h0000]), 32'h5A5A);
        chk("burst_word1", 32'(mem[14'h0101]), 32'hA001);
        chk("burst_word2", 32'(mem[14'h0102]), 32'hA002);

        // reset while a read is in flight
        req  = 3'b010;
        we   = 3'b000;
        addr = {16'h0, 16'h0010, 16'h0};
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        req = 3'b000;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
        chk("mid_rst_rdata", 32'(rdata), 32'h0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
        tick();
        chk("rst_no_rvalid", 32'(rvalid), 32'h0);
        rst = 1'b0;
        req  = 3'b011;
        addr = {16'h0, 16'h0010, 16'h0010};
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_rvalid", 32'(rvalid), 32'h0);
        req = 3'b000;
        tick();
        chk("post_rst_rv", 32'(rvalid), 32'h1);
        chk("post_rst_rdata", 32'(rdata), 32'hBEEF);

        // CPU-priority instance: CPU starves the others until it drops
        preq = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("prio_cpu%0d", i), 32'(pgnt), 32'h1);
        end
        preq = 3'b110;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("prio_rr%0d", i), 32'(pgnt), (i % 2 == 0) ? 32'h2 : 32'h4);
        end
        preq = 3'b000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
